// File: rtl/seq_load_ctrl.sv
// seq_load_ctrl: pops nucleotide characters from the UART RX FIFO, encodes them into the
// 3-bit system code and writes them into sequence memory A, then B. A '#' byte ends each
// sequence. Once both sequences are loaded, the NW core is started, and loading is held off
// until the core reports done.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_fifo_empty         RX FIFO empty flag (first-word fall-through)
//   i_fifo_data_out      head byte of the RX FIFO
//   o_fifo_rd            pop strobe (combinational)
//   o_char_wr            sequence memory write enable (registered)
//   o_char_sel           target memory, 0 = A, 1 = B (registered)
//   o_char_addr          write address (registered)
//   o_char               encoded nucleotide (registered)
//   o_len_a, o_len_b     committed sequence lengths (registered)
//   o_nw_start           one-cycle start pulse to the NW core
//   i_nw_done            NW core completion (pulse or level)
//   o_busy               high while the NW core is running
//   o_err                sticky error flag
module seq_load_ctrl #(
  parameter int unsigned N      = 8,
  parameter int unsigned LEN    = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fifo_empty,
  input  logic [N-1:0]      i_fifo_data_out,
  output logic              o_fifo_rd,
  output logic              o_char_wr,
  output logic              o_char_sel,
  output logic [ADDR_W-1:0] o_char_addr,
  output logic [2:0]        o_char,
  output logic [ADDR_W:0]   o_len_a,
  output logic [ADDR_W:0]   o_len_b,
  output logic              o_nw_start,
  input  logic              i_nw_done,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [ADDR_W:0] L_LEN = LEN[ADDR_W:0];

  localparam logic [N-1:0] C_G    = N'(8'h47);
  localparam logic [N-1:0] C_C    = N'(8'h43);
  localparam logic [N-1:0] C_A    = N'(8'h41);
  localparam logic [N-1:0] C_T    = N'(8'h54);
  localparam logic [N-1:0] C_TERM = N'(8'h23);

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_cnt;
  logic              r_char_wr;
  logic              r_char_sel;
  logic [ADDR_W-1:0] r_char_addr;
  logic [2:0]        r_char;
  logic [ADDR_W:0]   r_len_a;
  logic [ADDR_W:0]   r_len_b;
  logic              r_err;

  logic       w_loading;
  logic       w_pop;
  logic       w_is_nuc;
  logic       w_is_term;
  logic [2:0] w_code;
  logic       w_cnt_full;

  // Byte decode; anything not listed is junk that gets popped and dropped.
  always_comb begin
    w_is_nuc  = 1'b1;
    w_is_term = 1'b0;
    w_code    = 3'b000;
    unique case (i_fifo_data_out)
      C_G:     w_code = 3'b001;
      C_C:     w_code = 3'b110;
      C_A:     w_code = 3'b100;
      C_T:     w_code = 3'b011;
      C_TERM: begin
        w_is_nuc  = 1'b0;
        w_is_term = 1'b1;
      end
      default: w_is_nuc = 1'b0;
    endcase
  end

  assign w_loading  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
  // Gated by reset so every output reads 0 while reset is held.
  assign w_pop      = w_loading && !i_fifo_empty && !i_rst;
  assign w_cnt_full = (r_cnt == L_LEN);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_LOAD_A;
      r_cnt       <= '0;
      r_char_wr   <= 1'b0;
      r_char_sel  <= 1'b0;
      r_char_addr <= '0;
      r_char      <= 3'b000;
      r_len_a     <= '0;
      r_len_b     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_char_wr <= 1'b0;
      case (r_state)
        S_LOAD_A, S_LOAD_B: begin
          if (w_pop) begin
            if (w_is_nuc) begin
              if (w_cnt_full) begin
                r_err   <= 1'b1;
                r_state <= S_ERROR;
              end else begin
                r_char_wr   <= 1'b1;
                r_char      <= w_code;
                r_char_addr <= r_cnt[ADDR_W-1:0];
                r_char_sel  <= (r_state == S_LOAD_B);
                r_cnt       <= r_cnt + 1'b1;
              end
            end else if (w_is_term) begin
              if (r_cnt == '0) begin
                r_err   <= 1'b1;
                r_state <= S_ERROR;
              end else begin
                r_cnt <= '0;
                if (r_state == S_LOAD_A) begin
                  r_len_a <= r_cnt;
                  r_state <= S_LOAD_B;
                end else begin
                  r_len_b <= r_cnt;
                  r_state <= S_START;
                end
              end
            end
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_nw_done) begin
            r_state <= S_LOAD_A;
          end
        end
        S_ERROR: r_state <= S_ERROR;
        default: begin
          r_err   <= 1'b1;
          r_state <= S_ERROR;
        end
      endcase
    end
  end

  assign o_fifo_rd   = w_pop;
  assign o_char_wr   = r_char_wr;
  assign o_char_sel  = r_char_sel;
  assign o_char_addr = r_char_addr;
  assign o_char      = r_char;
  assign o_len_a     = r_len_a;
  assign o_len_b     = r_len_b;
  assign o_nw_start  = (r_state == S_START);
  assign o_busy      = (r_state == S_START) || (r_state == S_WAIT);
  assign o_err       = r_err;

endmodule

// File: tb/tb_seq_load_ctrl.sv
module tb_seq_load_ctrl;

  localparam int unsigned N      = 8;
  localparam int unsigned LEN    = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [N-1:0]      fifo_data = '0;
  logic              nw_done = 1'b0;
  logic              fifo_rd;
  logic              char_wr;
  logic              char_sel;
  logic [ADDR_W-1:0] char_addr;
  logic [2:0]        char_code;
  logic [ADDR_W:0]   len_a;
  logic [ADDR_W:0]   len_b;
  logic              nw_start;
  logic              busy;
  logic              err;

  seq_load_ctrl #(.N(N), .LEN(LEN), .ADDR_W(ADDR_W)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_data_out (fifo_data),
    .o_fifo_rd       (fifo_rd),
    .o_char_wr       (char_wr),
    .o_char_sel      (char_sel),
    .o_char_addr     (char_addr),
    .o_char          (char_code),
    .o_len_a         (len_a),
    .o_len_b         (len_b),
    .o_nw_start      (nw_start),
    .i_nw_done       (nw_done),
    .o_busy          (busy),
    .o_err           (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q[$];     // bench-side FIFO contents
  int         wlog[$];  // observed writes as {sel, addr, code}
  int         n_start = 0;

  // Behavioural model. Phase: 0 load A, 1 load B, 2 start, 3 running, 4 error.
  int m_ph, m_cnt;
  int e_wr, e_sel, e_addr, e_char, e_len_a, e_len_b, e_err;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int enc(input logic [7:0] b);
    case (b)
      8'h47:   return 1;
      8'h43:   return 6;
      8'h41:   return 4;
      8'h54:   return 3;
      8'h23:   return 8;
      default: return -1;
    endcase
  endfunction

  function automatic void model_reset();
    m_ph = 0; m_cnt = 0;
    e_wr = 0; e_sel = 0; e_addr = 0; e_char = 0;
    e_len_a = 0; e_len_b = 0; e_err = 0;
  endfunction

  function automatic void drive();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endfunction

  function automatic int wl(input int i);
    return (i < wlog.size()) ? wlog[i] : -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      e_wr = 0;
      if ((m_ph == 0 || m_ph == 1) && q.size() != 0) begin
        int c;
        c = enc(q.pop_front());
        if (c == 8) begin
          if (m_cnt == 0) begin
            e_err = 1; m_ph = 4;
          end else begin
            if (m_ph == 0) e_len_a = m_cnt; else e_len_b = m_cnt;
            m_cnt = 0;
            m_ph  = m_ph + 1;
          end
        end else if (c >= 0) begin
          if (m_cnt >= LEN) begin
            e_err = 1; m_ph = 4;
          end else begin
            e_wr = 1; e_char = c; e_addr = m_cnt; e_sel = m_ph;
            m_cnt++;
          end
        end
      end else if (m_ph == 2) begin
        m_ph = 3;
      end else if (m_ph == 3 && nw_done) begin
        m_ph = 0;
      end
      #1 drive();
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    check("fifo_rd",  fifo_rd,  ((m_ph == 0 || m_ph == 1) && q.size() != 0 && !rst) ? 1 : 0);
    check("char_wr",  char_wr,  e_wr);
    check("char_sel", char_sel, e_sel);
    check("char_addr", char_addr, e_addr);
    check("char",     char_code, e_char);
    check("len_a",    len_a,    e_len_a);
    check("len_b",    len_b,    e_len_b);
    check("nw_start", nw_start, (m_ph == 2) ? 1 : 0);
    check("busy",     busy,     (m_ph == 2 || m_ph == 3) ? 1 : 0);
    check("err",      err,      e_err);
    if (char_wr) wlog.push_back({char_sel, char_addr, char_code});
    if (nw_start) n_start++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    q.delete();
    drive();
    cyc(2);
    rst = 1'b0;
    wlog.delete();
    n_start = 0;
    cyc(1);
  endtask

  task automatic pulse_done();
    nw_done = 1'b1;
    cyc(1);
    nw_done = 1'b0;
  endtask

  initial begin
    model_reset();
    drive();
    cyc(1);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // Clean two-sequence load.
    push_str("GAT#CA#");
    cyc(10);
    check("t1_n_writes", wlog.size(), 5);
    check("t1_w0", wl(0), 'h01);
    check("t1_w1", wl(1), 'h0C);
    check("t1_w2", wl(2), 'h13);
    check("t1_w3", wl(3), 'h86);
    check("t1_w4", wl(4), 'h8C);
    check("t1_len_a", len_a, 3);
    check("t1_len_b", len_b, 2);
    check("t1_starts", n_start, 1);
    check("t1_busy", busy, 1);
    pulse_done();

    // Junk bytes interleaved.
    wlog.delete();
    n_start = 0;
    push_str("G\r\nxC#T#");
    cyc(12);
    check("t2_n_writes", wlog.size(), 3);
    check("t2_w0", wl(0), 'h01);
    check("t2_w1", wl(1), 'h0E);
    check("t2_w2", wl(2), 'h83);
    check("t2_len_a", len_a, 2);
    check("t2_len_b", len_b, 1);
    check("t2_starts", n_start, 1);

    // FIFO held while the core runs.
    push_str("TT#");
    for (int i = 0; i < 20; i++) begin
      check("t5_hold_rd", fifo_rd, 0);
      cyc(1);
    end
    wlog.delete();
    pulse_done();
    check("t5_busy_fall", busy, 0);
    check("t5_pop", fifo_rd, 1);
    cyc(1);
    check("t5_wr", char_wr, 1);
    check("t5_w0", wl(0), 'h03);
    cyc(3);

    // Empty first sequence.
    do_reset();
    push_str("#GC#");
    cyc(3);
    check("t4_err", err, 1);
    check("t4_no_writes", wlog.size(), 0);
    check("t4_rd", fifo_rd, 0);

    // Overflow on the 17th nucleotide.
    do_reset();
    for (int i = 0; i < 18; i++) q.push_back(8'h41);
    drive();
    cyc(24);
    check("t3_n_writes", wlog.size(), 16);
    for (int i = 0; i < 16; i++) check("t3_w", wl(i), i * 8 + 4);
    check("t3_err", err, 1);
    check("t3_rd", fifo_rd, 0);
    check("t3_starts", n_start, 0);

    // Reset mid-load.
    do_reset();
    push_str("GGA");
    cyc(4);
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rd", fifo_rd, 0);
    check("t6_wr", char_wr, 0);
    check("t6_char", char_code, 0);
    check("t6_addr", char_addr, 0);
    check("t6_len_a", len_a, 0);
    check("t6_busy", busy, 0);
    check("t6_err", err, 0);
    cyc(1);
    rst = 1'b0;
    wlog.delete();
    push_str("C#");
    cyc(4);
    check("t6_n_writes", wlog.size(), 1);
    check("t6_w0", wl(0), 'h06);
    check("t6_len_a_after", len_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_load_ctrl.md
Name: seq_load_ctrl

Overview:
- Controller that sequences loading of the two DNA sequences for the Needleman-Wunsch core from the UART RX FIFO.
- Pops bytes from the FIFO and encodes each nucleotide into the 3-bit system code.
- Writes codes into sequence memory A, then sequence memory B, using '#' as the terminator of each sequence.
- Then launches the NW core and blocks further loading until the core reports done.

Parameters:
- N, 8, width of the FIFO data byte.
- LEN, 16, maximum nucleotides per sequence.
- ADDR_W, 4, sequence memory address width; must satisfy 2^ADDR_W >= LEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- fifo_empty  in  1  RX FIFO empty flag; first-word fall-through, so fifo_data_out is valid whenever fifo_empty=0.
- fifo_data_out  in  N  head byte of the RX FIFO.
- fifo_rd  out  1  pop strobe, combinational.
- char_wr  out  1  sequence memory write enable, registered.
- char_sel  out  1  target memory: 0 = A, 1 = B; registered.
- char_addr  out  ADDR_W  write address, registered.
- char  out  3  encoded nucleotide, registered.
- len_a  out  ADDR_W+1  committed length of sequence A, registered.
- len_b  out  ADDR_W+1  committed length of sequence B, registered.
- nw_start  out  1  one-cycle start pulse to the NW core.
- nw_done  in  1  NW core completion, single-cycle pulse or level.
- busy  out  1  high while the NW core is running.
- err  out  1  sticky error flag.

Behaviour:
- Reset value is 0 for every output; state=LOAD_A; internal count cnt=0.
- Encoding, exact match on fifo_data_out:
  - 0x47 'G' -> 001
  - 0x43 'C' -> 110
  - 0x41 'A' -> 100
  - 0x54 'T' -> 011
  - 0x23 '#' -> terminator
  - Any other byte (CR, LF, lowercase, ...) is popped and discarded with no write and no error.
- States: LOAD_A, LOAD_B, START, WAIT_DONE, ERROR.
- fifo_rd = (state==LOAD_A or LOAD_B) and !fifo_empty. The block pops one byte per cycle and decodes it in the same cycle it is popped.
- LOAD_A / LOAD_B, on each pop:
  - Nucleotide with cnt<LEN: next cycle char_wr=1, char=code, char_addr=cnt, char_sel=0 (A) or 1 (B); cnt<=cnt+1.
  - Nucleotide with cnt==LEN: overflow. No write; err<=1; go to ERROR.
  - '#' with cnt==0: empty sequence. err<=1; go to ERROR.
  - '#' with cnt>0: latch len_a (or len_b) <= cnt; cnt<=0.
    - From LOAD_A, go to LOAD_B.
    - From LOAD_B, go to START.
  - fifo_empty=1: no pop, state and cnt hold.
- char_wr is high only in the cycle after a nucleotide pop. char, char_addr and char_sel hold their last values otherwise.
- START lasts one cycle: nw_start=1, busy=1, fifo_rd=0; then go to WAIT_DONE. nw_start is asserted in the cycle immediately after the B-terminator pop.
- WAIT_DONE: busy=1, fifo_rd=0; FIFO contents are retained. On nw_done=1, go to LOAD_A next cycle with busy=0.
- nw_done is ignored in every state except WAIT_DONE.
- len_a/len_b stay stable through START and WAIT_DONE. Each is overwritten only by its next terminator.
- ERROR is terminal until rst: fifo_rd=0, char_wr=0, nw_start=0, err=1.
- Asynchronous rst at any point, including mid-load or mid-run, immediately forces the reset values above. Partially loaded data is abandoned, and the next load starts at address 0 of A.

Test Plan:
- FIFO "GAT#CA#" with no gaps:
  - A writes addr0=001, addr1=100, addr2=011.
  - len_a=3.
  - B writes addr0=110, addr1=100.
  - len_b=2.
  - nw_start is high exactly one cycle, the cycle after the second '#' pop; busy=1.
- "G\r\nxC#T#" (0x0D, 0x0A, 0x78 interleaved):
  - Junk bytes are popped with no char_wr.
  - A addrs 0,1 = 001,110; len_a=2; len_b=1.
- LEN=16, feed 17 'A' bytes:
  - 16 writes at addr 0..15.
  - The 17th pop sets err=1.
  - fifo_rd stays 0 thereafter with FIFO non-empty; nw_start never asserts.
- "#GC#" -> err=1 after the first pop; no writes.
- After a start, preload "TT#":
  - fifo_rd=0 for 20 cycles of WAIT_DONE.
  - Pulse nw_done: busy falls; the next cycle pops 'T' and writes A addr0=011.
- Feed "GGA", then pulse rst for one cycle, then feed "C#":
  - All outputs are 0 during rst.
  - 'C' is written to A addr0; len_a=1.
